seg_display_scan: RTL and testbench

- Parametrised successor to the team's strobed 7-segment driver. Multiplexes DIGITS common-anode/cathode digits from a single binary input.
- Adds:
  - signed (two's-complement) display with minus sign;
  - sequential binary-to-BCD conversion latched once per frame, so digits never tear mid-frame;
  - overflow indication;
  - configurable segment and digit polarity;
  - anti-ghosting blanking.
- Sits between datapath registers and board LED pins.

---
 rtl/seg_display_pkg.sv | 52 +++++
 rtl/seg_display_scan_bin2bcd_seq.sv | 93 +++++++++
 rtl/seg_display_scan.sv | 184 ++++++++++++++++++
 tb/tb_seg_display_scan.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: glyph patterns
// (bit0..6 = a..g, bit7 = dp, active-high), converter states, nibble-to-glyph lookup.
package seg_display_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_e;

    function automatic logic [7:0] glyph(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scan_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, optional two's-complement
// magnitude, overflow when the result needs more than DIGITS decimal digits.
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_signed,
    input  logic [DATA_W-1:0]   bin,
    output logic                busy,
    output logic                done,
    output logic                neg,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    // Every 3 binary bits add at most one decimal digit (2^3 < 10).
    localparam int BCD_RAW = (DATA_W + 2) / 3;
    localparam int BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
    localparam int CNT_W   = $clog2(DATA_W);

    conv_state_e          state_q, state_d;
    logic [DATA_W-1:0]    mag_q, mag_d;
    logic [4*BCD_N-1:0]   acc_q, acc_d, adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    always_comb begin
        for (int i = 0; i < BCD_N; i++) begin
            adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        unique case (state_q)
            CONV_IDLE: if (start) state_d = CONV_LOAD;
            CONV_LOAD: begin
                // The most negative input negates to itself, which is its correct unsigned magnitude.
                neg_d   = is_signed & bin[DATA_W-1];
                mag_d   = neg_d ? -bin : bin;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                acc_d = {adj[4*BCD_N-2:0], mag_q[DATA_W-1]};
                mag_d = {mag_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = CONV_DONE;
            end
            CONV_DONE: state_d = CONV_IDLE;
            default:   state_d = CONV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        ovf = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++) ovf = ovf | (acc_q[4*i +: 4] != 4'd0);
    end

    assign busy = (state_q != CONV_IDLE);
    assign done = (state_q == CONV_DONE);
    assign neg  = neg_q;
    assign bcd  = acc_q[4*DIGITS-1:0];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment scanner with per-frame value capture, signed decimal or hex display.
// Optional SEG_DISPLAY_SCAN_BRIGHTNESS_EN adds a 4-bit brightness input (PWM inside each slot).
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int DIGITS             = 4,
    parameter int DATA_W             = 14,
    parameter int DROP_LEADING_ZEROS = 1,
    parameter int DISPLAY_AS_DEC     = 1,
    parameter int CLK_FREQ           = 50000000,
    parameter int REFRESH_HZ         = 90,
    parameter int BLANK_CYCLES       = 4,
    parameter int SEG_ACTIVE_LOW     = 0,
    parameter int DIG_ACTIVE_LOW     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        datain,
    input  logic                     data_signed,
    input  logic [$clog2(DIGITS):0]  decimal_place_location,
    input  logic                     show_decimal_place,
`ifdef SEG_DISPLAY_SCAN_BRIGHTNESS_EN
    input  logic [3:0]               brightness,
`endif
    output logic [7:0]               dataout,
    output logic [DIGITS-1:0]        seg,
    output logic                     overflow
);

    localparam int DIV   = CLK_FREQ / (REFRESH_HZ * DIGITS);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int LOC_W = IDX_W + 1;
    localparam int EXT_W = (DATA_W > 4*DIGITS) ? DATA_W : 4*DIGITS;
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    if (DIV < DATA_W + 4 + BLANK_CYCLES) begin : g_div_too_small
        $error("seg_display_scan: slot too short for conversion plus blanking");
    end

    function automatic logic [LOC_W-1:0] msd_of(input logic [4*DIGITS-1:0] d);
        msd_of = '0;
        for (int i = 1; i < DIGITS; i++) if (d[4*i +: 4] != 4'd0) msd_of = LOC_W'(i);
    endfunction

    function automatic int lead_of(input logic [LOC_W-1:0] msd, input logic [LOC_W-1:0] loc,
                                   input logic show);
        return (show && loc > msd) ? int'(loc) : int'(msd);
    endfunction

    logic [CNT_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tick, wrap;
    logic [DATA_W-1:0]   frame_data_q;
    logic                frame_signed_q, frame_show_q;
    logic [LOC_W-1:0]    frame_loc_q;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                neg_q, neg_d, ovf_q, ovf_d;
    logic [LOC_W-1:0]    msd_q, msd_d;
    logic [7:0]          dataout_q, dataout_d, glyph_raw;
    logic [DIGITS-1:0]   seg_q, seg_d;
    logic                dig_on;
    int                  lead;
    logic [EXT_W-1:0]    hex_ext;
    logic [4*DIGITS-1:0] hex_nib;
    logic                conv_done, conv_neg, conv_ovf;
    logic [4*DIGITS-1:0] conv_bcd;

    assign tick    = (div_q == CNT_W'(DIV - 1));
    assign wrap    = tick && (idx_q == IDX_W'(DIGITS - 1));
    assign div_d   = tick ? '0 : div_q + CNT_W'(1);
    assign idx_d   = !tick ? idx_q : (wrap ? '0 : idx_q + IDX_W'(1));
    assign hex_ext = EXT_W'(datain);
    assign hex_nib = hex_ext[4*DIGITS-1:0];

    if (DISPLAY_AS_DEC != 0) begin : g_dec
        logic conv_busy;
        bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (wrap && !conv_busy),
            .is_signed (frame_signed_q),
            .bin       (frame_data_q),
            .busy      (conv_busy),
            .done      (conv_done),
            .neg       (conv_neg),
            .bcd       (conv_bcd),
            .ovf       (conv_ovf)
        );
    end else begin : g_hex
        assign conv_done = 1'b0;
        assign conv_neg  = 1'b0;
        assign conv_ovf  = 1'b0;
        assign conv_bcd  = '0;
    end

    // Shadow digits change only at conversion end (or frame start in hex), so frames never tear.
    always_comb begin
        shadow_d = shadow_q;
        neg_d    = neg_q;
        msd_d    = msd_q;
        ovf_d    = ovf_q;
        if (DISPLAY_AS_DEC != 0) begin
            if (conv_done) begin
                shadow_d = conv_bcd;
                neg_d    = conv_neg;
                msd_d    = msd_of(conv_bcd);
                ovf_d    = conv_ovf ||
                           (conv_neg && lead_of(msd_d, frame_loc_q, frame_show_q) + 1 >= DIGITS);
            end
        end else if (wrap) begin
            shadow_d = hex_nib;
            neg_d    = 1'b0;
            msd_d    = msd_of(hex_nib);
            ovf_d    = 1'b0;
        end
    end

    // Outputs are computed for the next cycle's slot position so the register lands one cycle after tick.
    always_comb begin
        lead = lead_of(msd_q, frame_loc_q, frame_show_q);
        if (ovf_q) begin
            glyph_raw = SEG_MINUS;
        end else begin
            if (neg_q && int'(idx_d) == lead + 1)
                glyph_raw = SEG_MINUS;
            else if (DROP_LEADING_ZEROS != 0 && int'(idx_d) > lead)
                glyph_raw = SEG_BLANK;
            else
                glyph_raw = glyph(shadow_q[4*idx_d +: 4]);
            if (frame_show_q && frame_loc_q == {1'b0, idx_d}) glyph_raw[7] = 1'b1;
        end
    end

`ifdef SEG_DISPLAY_SCAN_BRIGHTNESS_EN
    localparam int ACTIVE = DIV - BLANK_CYCLES;
    logic [3:0] sub_phase;
    assign sub_phase = 4'(((int'(div_d) - BLANK_CYCLES) * 16) / ACTIVE);
    assign dig_on    = (div_d >= CNT_W'(BLANK_CYCLES)) && (sub_phase <= brightness);
`else
    assign dig_on    = (div_d >= CNT_W'(BLANK_CYCLES));
`endif

    assign dataout_d = glyph_raw ^ SEG_OFF;
    assign seg_d     = (dig_on ? (DIGITS'(1) << idx_d) : {DIGITS{1'b0}}) ^ DIG_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q          <= '0;
            idx_q          <= '0;
            frame_data_q   <= '0;
            frame_signed_q <= 1'b0;
            frame_loc_q    <= '0;
            frame_show_q   <= 1'b0;
            shadow_q       <= '0;
            neg_q          <= 1'b0;
            msd_q          <= '0;
            ovf_q          <= 1'b0;
            dataout_q      <= SEG_OFF;
            seg_q          <= DIG_OFF;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            neg_q     <= neg_d;
            msd_q     <= msd_d;
            ovf_q     <= ovf_d;
            dataout_q <= dataout_d;
            seg_q     <= seg_d;
            if (wrap) begin
                frame_data_q   <= datain;
                frame_signed_q <= data_signed;
                frame_loc_q    <= decimal_place_location;
                frame_show_q   <= show_decimal_place;
            end
        end
    end

    assign dataout  = dataout_q;
    assign seg      = seg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan at DIV = 64000/(100*4) = 160 cycles per slot.
module tb_seg_display_scan;

    localparam logic [7:0] G0 = 8'h3F, G1 = 8'h06, G2 = 8'h5B, G4 = 8'h66, G5 = 8'h6D;
    localparam logic [7:0] G6 = 8'h7D, G7 = 8'h07, G8 = 8'h7F, G9 = 8'h6F;
    localparam logic [7:0] G3 = 8'h4F, GM = 8'h40, GB = 8'h00, DP = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [13:0] datain = 14'd1234;
    logic        data_signed = 1'b0;
    logic [2:0]  decimal_place_location = 3'd0;
    logic        show_decimal_place = 1'b0;
    logic [7:0]  dataout;
    logic [3:0]  seg;
    logic        overflow;
`ifdef SEG_DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0]  brightness = 4'hF;
`endif

    int total = 0;
    int bad = 0;

    seg_display_scan #(
        .DIGITS(4), .DATA_W(14), .CLK_FREQ(64000), .REFRESH_HZ(100)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .datain                 (datain),
        .data_signed            (data_signed),
        .decimal_place_location (decimal_place_location),
        .show_decimal_place     (show_decimal_place),
`ifdef SEG_DISPLAY_SCAN_BRIGHTNESS_EN
        .brightness             (brightness),
`endif
        .dataout                (dataout),
        .seg                    (seg),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns at the first negedge where digit 0 is lit after having been dark.
    task automatic wait_slot0(input string tag);
        int n = 0;
        while (seg == 4'b0001 && n < 2000) begin @(negedge clk); n++; end
        while (seg != 4'b0001 && n < 4000) begin @(negedge clk); n++; end
        check({tag, "_sync"}, 32'(seg), 32'h1);
    endtask

    // exp = {digit3, digit2, digit1, digit0}; each slot sampled mid-way through.
    task automatic check_frame(input string tag, input logic [31:0] exp, input logic exp_ovf);
        logic [31:0] one_hot;
        wait_slot0(tag);
        repeat (80) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            one_hot = 32'h1 << d;
            check($sformatf("%s_seg%0d", tag, d), 32'(seg), one_hot);
            check($sformatf("%s_dig%0d", tag, d), 32'(dataout), 32'(exp[8*d +: 8]));
            check($sformatf("%s_ovf%0d", tag, d), 32'(overflow), 32'(exp_ovf));
            if (d < 3) repeat (160) @(negedge clk);
        end
    endtask

    initial begin
        #(1ms);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int on_cnt, blank_cnt, period;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dataout", 32'(dataout), 32'h00);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;

        check_frame("first_zero", {GB, GB, GB, G0}, 1'b0);
        check_frame("u1234", {G1, G2, G3, G4}, 1'b0);

        wait_slot0("timing");
        on_cnt = 0;
        while (seg == 4'b0001 && on_cnt < 1000) begin on_cnt++; @(negedge clk); end
        blank_cnt = 0;
        while (seg == 4'b0000 && blank_cnt < 1000) begin blank_cnt++; @(negedge clk); end
        period = on_cnt + blank_cnt;
        while (seg != 4'b0001 && period < 2000) begin period++; @(negedge clk); end
        check("slot_on_cycles", 32'(on_cnt), 32'd156);
        check("slot_blank_cycles", 32'(blank_cnt), 32'd4);
        check("frame_period", 32'(period), 32'd640);

        datain = 14'd7;
        check_frame("u7", {GB, GB, GB, G7}, 1'b0);
        datain = 14'd0;
        check_frame("u0", {GB, GB, GB, G0}, 1'b0);
        datain = 14'd7; decimal_place_location = 3'd2; show_decimal_place = 1'b1;
        check_frame("dp2", {GB, G0 | DP, G0, G7}, 1'b0);
        show_decimal_place = 1'b0; decimal_place_location = 3'd0;

        data_signed = 1'b1; datain = 14'h3FD3;
        check_frame("s_m45", {GB, GM, G4, G5}, 1'b0);
        datain = 14'h3C19;
        check_frame("s_m999", {GM, G9, G9, G9}, 1'b0);
        datain = 14'h3B2E;
        check_frame("s_m1234", {GM, GM, GM, GM}, 1'b1);

        data_signed = 1'b0; datain = 14'd12000;
        check_frame("u12000", {GM, GM, GM, GM}, 1'b1);
        datain = 14'd9999;
        wait_slot0("ovf_clear");
        check("ovf_held_before_done", 32'(overflow), 32'h1);
        repeat (80) @(negedge clk);
        check("ovf_cleared_after_done", 32'(overflow), 32'h0);
        check("ovf_clear_dig0", 32'(dataout), 32'(G9));
        check_frame("u9999", {G9, G9, G9, G9}, 1'b0);

        datain = 14'd1111;
        check_frame("u1111", {G1, G1, G1, G1}, 1'b0);
        wait_slot0("midframe");
        repeat (320) @(negedge clk);
        datain = 14'd2222;
        repeat (80) @(negedge clk);
        check("mid_slot2_seg", 32'(seg), 32'h4);
        check("mid_slot2_dig", 32'(dataout), 32'(G1));
        repeat (160) @(negedge clk);
        check("mid_slot3_seg", 32'(seg), 32'h8);
        check("mid_slot3_dig", 32'(dataout), 32'(G1));
        check_frame("u2222", {G2, G2, G2, G2}, 1'b0);

        datain = 14'd12000;
        check_frame("pre_rst_ovf", {GM, GM, GM, GM}, 1'b1);
        datain = 14'd5678;
        wait_slot0("rst_shift");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_dataout", 32'(dataout), 32'h00);
        check("async_rst_seg", 32'(seg), 32'h0);
        check("async_rst_ovf", 32'(overflow), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_frame("post_rst_zero", {GB, GB, GB, G0}, 1'b0);
        check_frame("u5678", {G5, G6, G7, G8}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
